// File: rtl/dbus_rd_seq.sv
// Read sequencer: splits one 8/16/32/64-bit read into memory-width beats and steers datapath lanes.
// Optional `DBUS_RD_TIMEOUT_EN adds a WAIT-cycle watchdog that aborts via an ERR state.
module dbus_rd_seq #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       resetl,
    input  logic       start,
    input  logic [1:0] size,
    input  logic [2:0] offset,
    input  logic [1:0] mwidth,
    input  logic       ourack,
    output logic       mreq,
    output logic [2:0] beat_addr,
    output logic [7:0] dinlatch,
    output logic [2:0] dmuxu,
    output logic [2:0] dmuxd,
    output logic       dren,
    output logic       busy,
    output logic       done,
    output logic       err
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("dbus_rd_seq: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] base_q;
    logic [1:0] blg_q;
    logic [1:0] wlg_q;
    logic [2:0] last_q;
    logic [2:0] k_q;

`ifdef DBUS_RD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q;
`endif

    // Clear the low address bits covered by a 2^lg-byte unit.
    function automatic logic [2:0] align_down(input logic [2:0] a, input logic [1:0] lg);
        return a & ~3'((4'd1 << lg) - 4'd1);
    endfunction

    logic [1:0] blg_c;
    logic [2:0] last_c;
    logic [2:0] base_c;
    logic [2:0] k_nx;
    logic [2:0] dest_nx;

    always_comb begin
        blg_c   = (size < mwidth) ? size : mwidth;
        last_c  = 3'((4'd1 << (size - blg_c)) - 4'd1);
        base_c  = align_down(offset, size);
        k_nx    = 3'(k_q + 3'd1);
        dest_nx = 3'(base_q + 3'(k_nx << blg_q));
    end

    // Only unregistered output: lane enables follow ourack within the beat.
    logic [7:0] lane_mask;

    always_comb begin
        lane_mask = 8'h00;
        case (blg_q)
            2'd0: lane_mask = 8'h01;
            2'd1: lane_mask = 8'h03;
            2'd2: lane_mask = 8'h0F;
            2'd3: lane_mask = 8'hFF;
            default: lane_mask = 8'h00;
        endcase
        dinlatch = 8'h00;
        if (state == WAIT && ourack) begin
            dinlatch = 8'(lane_mask << beat_addr);
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state     <= IDLE;
            base_q    <= 3'd0;
            blg_q     <= 2'd0;
            wlg_q     <= 2'd0;
            last_q    <= 3'd0;
            k_q       <= 3'd0;
            mreq      <= 1'b0;
            beat_addr <= 3'd0;
            dmuxu     <= 3'd0;
            dmuxd     <= 3'd0;
            dren      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef DBUS_RD_TIMEOUT_EN
            tcnt_q    <= '0;
`endif
        end else begin
            dren <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAIT;
                        base_q    <= base_c;
                        blg_q     <= blg_c;
                        wlg_q     <= mwidth;
                        last_q    <= last_c;
                        k_q       <= 3'd0;
                        mreq      <= 1'b1;
                        busy      <= 1'b1;
                        beat_addr <= base_c;
                        dmuxu     <= align_down(base_c, mwidth);
                        dmuxd     <= base_c;
`ifdef DBUS_RD_TIMEOUT_EN
                        tcnt_q    <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (ourack) begin
`ifdef DBUS_RD_TIMEOUT_EN
                        tcnt_q <= '0;
`endif
                        if (k_q == last_q) begin
                            state     <= DRIVE;
                            mreq      <= 1'b0;
                            beat_addr <= 3'd0;
                            dmuxu     <= 3'd0;
                            dren      <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            k_q       <= k_nx;
                            beat_addr <= dest_nx;
                            dmuxu     <= align_down(dest_nx, wlg_q);
                        end
                    end
`ifdef DBUS_RD_TIMEOUT_EN
                    else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        state     <= ERR;
                        mreq      <= 1'b0;
                        beat_addr <= 3'd0;
                        dmuxu     <= 3'd0;
                        err       <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        tcnt_q <= TW'(tcnt_q + 1'b1);
                    end
`endif
                end
                DRIVE, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    dmuxd <= 3'd0;
                    k_q   <= 3'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_rd_seq.sv
// Self-checking bench for dbus_rd_seq: directed scenarios plus randomized reads against a beat-level model.
module tb_dbus_rd_seq;

    logic       clk;
    logic       resetl;
    logic       start;
    logic [1:0] size;
    logic [2:0] offset;
    logic [1:0] mwidth;
    logic       ourack;
    logic       mreq;
    logic [2:0] beat_addr;
    logic [7:0] dinlatch;
    logic [2:0] dmuxu;
    logic [2:0] dmuxd;
    logic       dren;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    dbus_rd_seq #(.TIMEOUT(64)) dut (
        .clk       (clk),
        .resetl    (resetl),
        .start     (start),
        .size      (size),
        .offset    (offset),
        .mwidth    (mwidth),
        .ourack    (ourack),
        .mreq      (mreq),
        .beat_addr (beat_addr),
        .dinlatch  (dinlatch),
        .dmuxu     (dmuxu),
        .dmuxd     (dmuxd),
        .dren      (dren),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mreq, beat_addr, dinlatch, dmuxu, dmuxd, dren, busy, done, err}
    logic [21:0] ov;
    assign ov = {mreq, beat_addr, dinlatch, dmuxu, dmuxd, dren, busy, done, err};

    // Cycles start 1 time unit after the rising edge; inputs change there, outputs are sampled 3 units later.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] sz, input logic [2:0] off, input logic [1:0] mw);
        start  = 1'b1;
        size   = sz;
        offset = off;
        mwidth = mw;
        adv();
        start  = 1'b0;
        size   = 2'($urandom);
        offset = 3'($urandom);
        mwidth = 2'($urandom);
    endtask

    task automatic test_reset();
        resetl = 1'b0;
        start  = 1'b0;
        ourack = 1'b0;
        size   = 2'd0;
        offset = 3'd0;
        mwidth = 2'd0;
        #3;
        checks++;
        if (ov !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", ov, 22'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        resetl = 1'b1;
        adv();
        #3;
        checks++;
        if (ov !== 22'd0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h exp=%h", ov, 22'd0);
        end
        adv();
    endtask

    task automatic test_phrase16();
        logic [7:0] dl [4];
        dl = '{8'h03, 8'h0C, 8'h30, 8'hC0};
        launch(2'd3, 3'd0, 2'd1);
        for (int k = 0; k < 4; k++) begin
            ourack = 1'b1;
            #3;
            checks++;
            if ({mreq, beat_addr, dinlatch, dmuxu, dmuxd} !== {1'b1, 3'(2 * k), dl[k], 3'(2 * k), 3'd0}) begin
                failures++;
                $display("FAIL phrase16_beat%0d got=%h exp=%h", k,
                         {mreq, beat_addr, dinlatch, dmuxu, dmuxd},
                         {1'b1, 3'(2 * k), dl[k], 3'(2 * k), 3'd0});
            end
            adv();
        end
        ourack = 1'b0;
        #3;
        checks++;
        if ({dren, done, busy, err, dmuxd} !== {4'b1110, 3'd0}) begin
            failures++;
            $display("FAIL phrase16_drive got=%b exp=%b", {dren, done, busy, err, dmuxd}, {4'b1110, 3'd0});
        end
        adv();
        #3;
        checks++;
        if (ov !== 22'd0) begin
            failures++;
            $display("FAIL phrase16_idle got=%h exp=%h", ov, 22'd0);
        end
        adv();
    endtask

    task automatic test_byte64();
        launch(2'd0, 3'd5, 2'd3);
        for (int c = 1; c <= 3; c++) begin
            ourack = (c == 3);
            #3;
            checks++;
            if ({mreq, busy, dinlatch, dmuxu, dmuxd, done} !== {2'b11, (c == 3) ? 8'h20 : 8'h00, 3'd0, 3'd5, 1'b0}) begin
                failures++;
                $display("FAIL byte64_cycle%0d got=%h exp=%h", c, {mreq, busy, dinlatch, dmuxu, dmuxd, done},
                         {2'b11, (c == 3) ? 8'h20 : 8'h00, 3'd0, 3'd5, 1'b0});
            end
            adv();
        end
        ourack = 1'b0;
        #3;
        checks++;
        if ({mreq, done, dren} !== 3'b011) begin
            failures++;
            $display("FAIL byte64_done got=%b exp=%b", {mreq, done, dren}, 3'b011);
        end
        adv();
        adv();
    endtask

    task automatic test_long32();
        launch(2'd2, 3'd6, 2'd2);
        ourack = 1'b1;
        #3;
        checks++;
        if ({beat_addr, dinlatch, dmuxu, dmuxd} !== {3'd4, 8'hF0, 3'd4, 3'd4}) begin
            failures++;
            $display("FAIL long32_beat got=%h exp=%h", {beat_addr, dinlatch, dmuxu, dmuxd}, {3'd4, 8'hF0, 3'd4, 3'd4});
        end
        adv();
        ourack = 1'b0;
        #3;
        checks++;
        if ({done, dren, dmuxd} !== {2'b11, 3'd4}) begin
            failures++;
            $display("FAIL long32_done got=%b exp=%b", {done, dren, dmuxd}, {2'b11, 3'd4});
        end
        adv();
        adv();
    endtask

    task automatic test_word8_restart();
        int ndone = 0;
        launch(2'd1, 3'd3, 2'd0);
        start  = 1'b1;
        ourack = 1'b1;
        #3;
        checks++;
        if ({dinlatch, dmuxu, dmuxd} !== {8'h04, 3'd2, 3'd2}) begin
            failures++;
            $display("FAIL word8_beat0 got=%h exp=%h", {dinlatch, dmuxu, dmuxd}, {8'h04, 3'd2, 3'd2});
        end
        adv();
        #3;
        checks++;
        if ({dinlatch, dmuxu, dmuxd} !== {8'h08, 3'd3, 3'd2}) begin
            failures++;
            $display("FAIL word8_beat1 got=%h exp=%h", {dinlatch, dmuxu, dmuxd}, {8'h08, 3'd3, 3'd2});
        end
        adv();
        ourack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            start = (c == 0);
            #3;
            if (done) ndone++;
            adv();
        end
        checks++;
        if (ndone !== 1) begin
            failures++;
            $display("FAIL word8_single_done got=%0d exp=%0d", ndone, 1);
        end
        #3;
        checks++;
        if ({busy, mreq} !== 2'b00) begin
            failures++;
            $display("FAIL word8_no_requeue got=%b exp=%b", {busy, mreq}, 2'b00);
        end
        adv();
    endtask

    task automatic test_timeout();
`ifdef DBUS_RD_TIMEOUT_EN
        launch(2'd0, 3'd1, 2'd0);
        repeat (64) adv();
        #3;
        checks++;
        if ({err, done, dren, dinlatch, busy} !== {3'b110, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL timeout_err got=%h exp=%h", {err, done, dren, dinlatch, busy}, {3'b110, 8'h00, 1'b1});
        end
        adv();
        #3;
        checks++;
        if ({busy, err, done} !== 3'b000) begin
            failures++;
            $display("FAIL timeout_idle got=%b exp=%b", {busy, err, done}, 3'b000);
        end
        adv();
        launch(2'd0, 3'd1, 2'd0);
        repeat (63) adv();
        ourack = 1'b1;
        adv();
        ourack = 1'b0;
        #3;
        checks++;
        if ({done, err, dren} !== 3'b101) begin
            failures++;
            $display("FAIL timeout_ack_wins got=%b exp=%b", {done, err, dren}, 3'b101);
        end
        adv();
        adv();
`else
        launch(2'd0, 3'd1, 2'd0);
        repeat (100) adv();
        #3;
        checks++;
        if ({mreq, busy, err, done} !== 4'b1100) begin
            failures++;
            $display("FAIL wait_persists got=%b exp=%b", {mreq, busy, err, done}, 4'b1100);
        end
        ourack = 1'b1;
        adv();
        ourack = 1'b0;
        #3;
        checks++;
        if ({done, err, dren} !== 3'b101) begin
            failures++;
            $display("FAIL late_ack_done got=%b exp=%b", {done, err, dren}, 3'b101);
        end
        adv();
        adv();
`endif
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        launch(2'd3, 3'd0, 2'd1);
        ourack = 1'b1;
        adv();
        adv();
        ourack = 1'b0;
        #1;
        resetl = 1'b0;
        #1;
        checks++;
        if (ov !== 22'd0) begin
            failures++;
            $display("FAIL reset_mid_async got=%h exp=%h", ov, 22'd0);
        end
        for (int c = 0; c < 3; c++) begin
            adv();
            #3;
            if (done || err) ndone++;
        end
        resetl = 1'b1;
        adv();
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got=%0d exp=%0d", ndone, 0);
        end
        launch(2'd0, 3'd1, 2'd0);
        ourack = 1'b1;
        #3;
        checks++;
        if ({dinlatch, dmuxd} !== {8'h02, 3'd1}) begin
            failures++;
            $display("FAIL reset_mid_new_beat got=%h exp=%h", {dinlatch, dmuxd}, {8'h02, 3'd1});
        end
        adv();
        ourack = 1'b0;
        #3;
        checks++;
        if ({done, dren} !== 2'b11) begin
            failures++;
            $display("FAIL reset_mid_new_done got=%b exp=%b", {done, dren}, 2'b11);
        end
        adv();
        adv();
    endtask

    // Random reads: expected per-cycle outputs derived from byte counts, lane rule and beat schedule.
    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int sz, mw, off, sb, wb, b, n, base;
            bit poke;
            logic [21:0] exp;
            sz   = $urandom_range(3);
            mw   = $urandom_range(3);
            off  = $urandom_range(7);
            poke = 1'($urandom);
            sb   = 1 << sz;
            wb   = 1 << mw;
            b    = (sb < wb) ? sb : wb;
            n    = sb / b;
            base = off & ~(sb - 1);
            launch(2'(sz), 3'(off), 2'(mw));
            for (int k = 0; k < n; k++) begin
                int dest, wc;
                dest = (base + k * b) % 8;
                wc   = $urandom_range(3);
                for (int w = 0; w <= wc; w++) begin
                    bit ack;
                    ack    = (w == wc);
                    ourack = ack;
                    start  = poke && 1'($urandom);
                    #3;
                    exp = {1'b1, 3'(dest), ack ? 8'(((1 << b) - 1) << dest) : 8'h00,
                           3'(dest & ~(wb - 1)), 3'(base), 1'b0, 1'b1, 1'b0, 1'b0};
                    checks++;
                    if (ov !== exp) begin
                        failures++;
                        $display("FAIL rand%0d_beat%0d_w%0d sz=%0d mw=%0d off=%0d got=%h exp=%h",
                                 t, k, w, sz, mw, off, ov, exp);
                    end
                    adv();
                end
            end
            ourack = 1'($urandom);
            start  = poke;
            #3;
            exp = {1'b0, 3'd0, 8'h00, 3'd0, 3'(base), 1'b1, 1'b1, 1'b1, 1'b0};
            checks++;
            if (ov !== exp) begin
                failures++;
                $display("FAIL rand%0d_drive got=%h exp=%h", t, ov, exp);
            end
            adv();
            start  = 1'b0;
            ourack = 1'($urandom);
            #3;
            checks++;
            if (ov !== 22'd0) begin
                failures++;
                $display("FAIL rand%0d_idle got=%h exp=%h", t, ov, 22'd0);
            end
            adv();
            ourack = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_phrase16();
        test_byte64();
        test_long32();
        test_word8_restart();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbus_rd_seq.md
Name: dbus_rd_seq

Overview:
- Read sequencer for the Tom data bus datapath.
- Breaks one CPU/blitter read of 8/16/32/64 bits into one or more external memory beats, sized by the memory port width.
- Drives the datapath byte-lane latch enables (dinlatch), up/down alignment mux selects (dmuxu/dmuxd) and the data drive enable (dren).
- Sits between the memory interface ack path and the dbus datapath.

Parameters:
- TIMEOUT, 64, consecutive WAIT cycles without ack before the transfer aborts (only used with the optional feature).

Ports:
- clk  in  1  system clock; every register is on its rising edge.
- resetl  in  1  asynchronous active-low reset.
- start  in  1  one-cycle read request; accepted only when busy=0.
- size  in  2  read size: 0=byte, 1=word, 2=long, 3=phrase.
- offset  in  3  byte address bits [2:0] of the request.
- mwidth  in  2  memory port width: 0=8, 1=16, 2=32, 3=64 bits.
- ourack  in  1  memory ack; beat data is valid on din this cycle.
- mreq  out  1  beat request to memory, high in WAIT.
- beat_addr  out  3  byte address of the current beat.
- dinlatch  out  8  byte-lane latch enables to the datapath.
- dmuxu  out  3  up-shift, in bytes, for the current beat.
- dmuxd  out  3  down-shift, in bytes, for the final result.
- dren  out  1  datapath drive enable.
- busy  out  1  a transfer is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse.

Behaviour:
- Derived values:
  - SB = bytes of size = 1<<size.
  - WB = bytes of mwidth = 1<<mwidth.
  - B = min(SB, WB) bytes per beat.
  - N = SB/B beats, range 1..8.
  - base = offset & ~(SB-1).
- All of the above are latched at start. offset, size and mwidth are don't-care after start.
- Memory lane rule: memory presents byte address A on lane (A mod WB).
- FSM states: IDLE, WAIT, DRIVE, plus ERR under the optional feature.
- IDLE:
  - start=1 -> WAIT; beat counter k=0.
  - start is ignored in every other state (no queueing).
- WAIT:
  - mreq=1.
  - beat_addr = dest = (base + k*B) mod 8.
  - dmuxu = dest & ~(WB-1), registered and stable for the whole beat.
  - dinlatch = (B-bit mask at lane dest), gated by ourack. This is the only combinational output path: it is 0 in any cycle without ourack.
  - ourack and k<N-1: k increments, stay in WAIT.
  - ourack and k=N-1: -> DRIVE.
- DRIVE: one cycle; dren=1, done=1, then -> IDLE.
- dmuxd = base, valid from the cycle after start through DRIVE; 0 in IDLE.
- busy = 1 in WAIT, DRIVE and ERR.
- ourack outside WAIT is ignored.
- Latency: start in cycle 0, first ack no earlier than cycle 1, done one cycle after the last ack. Minimum is done in cycle 2.
- Reset values: all outputs 0, state IDLE, k=0.
- Reset asserted mid-transfer: immediate return to IDLE, no done or err pulse.

Optional Feature:
- Macro: DBUS_RD_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to WAIT and on each ack; increments on each WAIT cycle without ack.
  - When it reaches TIMEOUT -> ERR for one cycle: err=1, done=1, dren=0, dinlatch=0. Then -> IDLE.
  - An ack in the same cycle the count reaches TIMEOUT wins: the ack is taken and no error is raised.
- Undefined: no counter, WAIT persists until ack, err tied to 0.

Test Plan:
- Phrase read, mwidth=1 (16-bit), offset=0, acks in cycles 1, 2, 3, 4:
  - dinlatch = 0x03, 0x0C, 0x30, 0xC0.
  - dmuxu = 0, 2, 4, 6; beat_addr = 0, 2, 4, 6.
  - dmuxd = 0; dren=done=1 in cycle 5.
- Byte read, mwidth=3, offset=5, ack in cycle 3:
  - Single beat, dinlatch=0x20 in cycle 3, dmuxu=0, dmuxd=5.
  - done in cycle 4; mreq high in cycles 1-3.
- Long read, mwidth=2, offset=6: beat_addr=4, dinlatch=0xF0, dmuxu=4, dmuxd=4, one beat.
- Word read, mwidth=0, offset=3:
  - base=2, two beats, dinlatch = 0x04 then 0x08.
  - dmuxu = 2 then 3; dmuxd=2.
  - start pulsed again during WAIT is ignored, with exactly one done.
- With DBUS_RD_TIMEOUT_EN and TIMEOUT=64, no ack after start in cycle 0:
  - err=done=1 in cycle 65, dren=0, busy=0 in cycle 66.
  - Repeat with ack in cycle 64: normal done in cycle 65, err=0.
- resetl driven low mid-phrase (after 2 acks):
  - All outputs 0 asynchronously, no done.
  - A new byte read after release completes normally.
